fpadd_operand_sequencer: RTL and testbench

- Upstream feeder and result-capture stage for the pipelined floating-point adder.
- On each debounced start pulse it fetches the next operand pair from an internal table and drives it onto the adder inputs, holding it stable.
- It waits the adder's fixed pipeline latency, then captures the adder output into a result register and flags it valid.
- The captured result is what the LED / seven-segment display path shows.

---
 rtl/fpadd_operand_sequencer_if.sv | 55 +++++
 rtl/fpadd_operand_sequencer.sv | 159 +++++++++++++++
 tb/tb_fpadd_operand_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpadd_operand_sequencer_if
//  Description : Bus bundle between the operand sequencer and its
//                surroundings (debouncer, FP adder, display path).
//                  start        - request pulse from the debouncer
//                  fp_out       - adder result (IEEE-754 single)
//                  InpA / InpB  - adder operands
//                  result       - last captured adder result
//                  result_valid - one-cycle pulse while capturing
//                  busy         - operation in flight
//                  index        - table index of the operands on InpA/InpB
//                  op_count     - completed operations, wraps at 256
//                The master modport is the sequencer's view; the slave
//                modport is the environment's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpadd_operand_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              start;
  logic [31:0]       fp_out;
  logic [31:0]       InpA;
  logic [31:0]       InpB;
  logic [31:0]       result;
  logic              result_valid;
  logic              busy;
  logic [ADDR_W-1:0] index;
  logic [7:0]        op_count;

  modport master (
    input  start,
    input  fp_out,
    output InpA,
    output InpB,
    output result,
    output result_valid,
    output busy,
    output index,
    output op_count
  );

  modport slave (
    output start,
    output fp_out,
    input  InpA,
    input  InpB,
    input  result,
    input  result_valid,
    input  busy,
    input  index,
    input  op_count
  );
endinterface
`default_nettype wire

// File: rtl/fpadd_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpadd_operand_sequencer
//  Description : Feeds operand pairs from a fixed table into a pipelined
//                floating-point adder and captures the adder output once
//                the pipeline latency has elapsed. Each accepted start
//                pulse issues the next table entry; the captured result
//                drives the display path.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - fpadd_operand_sequencer_if.master (start, fp_out,
//                       InpA, InpB, result, result_valid, busy, index,
//                       op_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module fpadd_operand_sequencer #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int PIPE_LAT = 5
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  fpadd_operand_sequencer_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // Counter preload: WAIT lasts exactly PIPE_LAT cycles, ending when the
  // counter has reached zero.
  localparam logic [3:0] c_wait_init = 4'(PIPE_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_capture;
  logic [3:0]        r_wait_cnt;
  logic [31:0]       r_inp_a;
  logic [31:0]       r_inp_b;
  logic [31:0]       r_result;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_next_idx;
  logic [7:0]        r_op_count;
  logic [7:0]        w_sel;
  logic [63:0]       w_entry;

  // --------------------------------------------------------------------------
  // Operand table: {A, B}. Entries beyond the fixed list return 1.0 + 0.0.
  // --------------------------------------------------------------------------
  function automatic logic [63:0] table_entry(input logic [7:0] sel);
    logic [63:0] e;
    case (sel)
      8'd0:    e = {32'h3F80_0000, 32'h4000_0000};  //  1.0 +  2.0
      8'd1:    e = {32'h4040_0000, 32'hBF80_0000};  //  3.0 + -1.0
      8'd2:    e = {32'h0000_0000, 32'h0000_0000};  //  0.0 +  0.0
      8'd3:    e = {32'h7F80_0000, 32'h3F80_0000};  // +inf +  1.0
      8'd4:    e = {32'h3F00_0000, 32'h3F00_0000};  //  0.5 +  0.5
      8'd5:    e = {32'hC000_0000, 32'h4000_0000};  // -2.0 +  2.0
      8'd6:    e = {32'h4120_0000, 32'h41A0_0000};  // 10.0 + 20.0
      8'd7:    e = {32'h7F7F_FFFF, 32'h7F7F_FFFF};  // max  + max (overflow)
      default: e = {32'h3F80_0000, 32'h0000_0000};
    endcase
    return e;
  endfunction

  assign w_sel   = 8'(r_next_idx);
  assign w_entry = table_entry(w_sel);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start is only looked at in IDLE, so pulses while busy (including the
  // CAPTURE cycle) are dropped rather than queued.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Operands change only when entering ISSUE so the adder sees
  // constant inputs for the whole operation.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
      r_inp_a    <= 32'd0;
      r_inp_b    <= 32'd0;
      r_result   <= 32'd0;
      r_index    <= '0;
      r_next_idx <= '0;
      r_op_count <= 8'd0;
    end else begin
      if (w_load) begin
        r_inp_a <= w_entry[63:32];
        r_inp_b <= w_entry[31:0];
        r_index <= r_next_idx;
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= c_wait_init;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      if (w_capture) begin
        r_result   <= bus.fp_out;
        r_op_count <= r_op_count + 8'd1;
        // DEPTH is a power of two, so natural overflow wraps to entry 0.
        r_next_idx <= r_index + 1'b1;
      end
    end
  end

  assign bus.InpA         = r_inp_a;
  assign bus.InpB         = r_inp_b;
  assign bus.result       = r_result;
  assign bus.result_valid = w_capture;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.index        = r_index;
  assign bus.op_count     = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_fpadd_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpadd_operand_sequencer
//  Description : Self-checking bench for fpadd_operand_sequencer. A
//                behavioural adder (lookup of hand-computed sums delayed by
//                PIPE_LAT register stages) drives fp_out. A vector table
//                covers the issue/capture of every entry plus wrap; directed
//                sequences cover reset, mid-operation reset, dropped starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpadd_operand_sequencer;

  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int PIPE_LAT = 5;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  idx;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [DEPTH+1];

  fpadd_operand_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fpadd_operand_sequencer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: known operand pairs map to hand-computed sums.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000;
      {32'h0000_0000, 32'h0000_0000}: return 32'h0000_0000;
      {32'h7F80_0000, 32'h3F80_0000}: return 32'h7F80_0000;
      {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000;
      {32'hC000_0000, 32'h4000_0000}: return 32'h0000_0000;
      {32'h4120_0000, 32'h41A0_0000}: return 32'h41F0_0000;
      {32'h7F7F_FFFF, 32'h7F7F_FFFF}: return 32'h7F80_0000;
      default:                        return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0] pipe [PIPE_LAT];
  always @(posedge clk) begin
    pipe[0] <= fp_model(bus.InpA, bus.InpB);
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.fp_out = pipe[PIPE_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  // One full operation from a start pulse; returns at the negedge after
  // capture.
  task automatic run_op(input vec_t v, input logic [7:0] exp_cnt);
    int k;
    int toggles;
    bit seen;
    pulse_start();
    check("issue_inpa", bus.InpA, v.a);
    check("issue_inpb", bus.InpB, v.b);
    check("issue_index", 32'(bus.index), 32'(v.idx));
    check("issue_busy", 32'(bus.busy), 32'd1);
    k = 0; toggles = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.result_valid) seen = 1'b1;
      if (bus.InpA !== v.a || bus.InpB !== v.b || bus.busy !== 1'b1) toggles++;
    end
    check("valid_latency", 32'(k), 32'(PIPE_LAT + 1));
    check("wait_stable", 32'(toggles), 32'd0);
    @(negedge clk);
    check("result", bus.result, v.r);
    check("op_count", 32'(bus.op_count), 32'(exp_cnt));
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("valid_single", 32'(bus.result_valid), 32'd0);
    check("hold_inpa", bus.InpA, v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int k;
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    rst = 1'b0;

    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'd0};
    vecs[1] = '{32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 3'd1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'd2};
    vecs[3] = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'd3};
    vecs[4] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 3'd4};
    vecs[5] = '{32'hC000_0000, 32'h4000_0000, 32'h0000_0000, 3'd5};
    vecs[6] = '{32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000, 3'd6};
    vecs[7] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'd7};
    vecs[8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'd0};

    // Reset held with start toggling.
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.start = ~bus.start;
      if (bus.result_valid) nvalid++;
    end
    bus.start = 1'b0;
    check("rst_no_valid", 32'(nvalid), 32'd0);
    check("rst_inpa", bus.InpA, 32'd0);
    check("rst_inpb", bus.InpB, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_index", 32'(bus.index), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    @(negedge clk) rst = 1'b1;

    // All entries plus wrap back to entry 0.
    for (int i = 0; i < DEPTH + 1; i++) begin
      run_op(vecs[i], 8'(i + 1));
      repeat (2) @(negedge clk);
    end

    // Reset during WAIT: takes effect without a clock edge.
    pulse_start();
    repeat (3) @(negedge clk);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_result", bus.result, 32'd0);
    check("mid_index", 32'(bus.index), 32'd0);
    check("mid_op_count", 32'(bus.op_count), 32'd0);
    check("mid_inpa", bus.InpA, 32'd0);
    nvalid = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
    end
    rst = 1'b1;
    repeat (PIPE_LAT + 4) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
    end
    check("mid_no_valid", 32'(nvalid), 32'd0);
    check("mid_result_after", bus.result, 32'd0);

    // Second start two cycles after the first is dropped.
    pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    nvalid = 0;
    repeat (2 * (PIPE_LAT + 3)) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
      if (bus.index !== 3'd0) nvalid += 100;
    end
    check("drop_valid_count", 32'(nvalid), 32'd1);
    check("drop_result", bus.result, 32'h4040_0000);
    check("drop_op_count", 32'(bus.op_count), 32'd1);
    run_op(vecs[1], 8'd2);

    // Start arriving in the CAPTURE cycle is dropped.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    k = 0;
    while (!bus.result_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("cap_reached", 32'(bus.result_valid), 32'd1);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("cap_drop_busy", 32'(bus.busy), 32'd0);
    nvalid = 0;
    repeat (PIPE_LAT + 4) begin
      @(negedge clk);
      if (bus.result_valid) nvalid++;
    end
    check("cap_drop_valid", 32'(nvalid), 32'd0);
    check("cap_op_count", 32'(bus.op_count), 32'd3);
    check("cap_index", 32'(bus.index), 32'd2);
    check("cap_result", bus.result, 32'h0000_0000);
    run_op(vecs[3], 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
